// File: rtl/cordic_arb_pkg.sv
// Shared types and constants for the CORDIC phase-engine arbiter.
package cordic_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_OUTPUT = 2'd3
   } cordic_arb_state_e;

   localparam int DEF_BIT_WIDTH_IN  = 24;
   localparam int DEF_BIT_WIDTH_OUT = 26;

   // Width of a channel index; never below one bit.
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the lowest requester above the pointer
// wins, otherwise the lowest requester at or below it (wrap to 0).
module rr_arbiter
   import cordic_arb_pkg::*;
#(
   parameter int N_CH = 4
) (
   input  logic [N_CH-1:0]             req,
   input  logic [ch_idx_w(N_CH)-1:0]   ptr,
   output logic [N_CH-1:0]             gnt,
   output logic [ch_idx_w(N_CH)-1:0]   gnt_idx
);

   localparam int CH_W = ch_idx_w(N_CH);

   logic            hi_hit;
   logic            lo_hit;
   logic [CH_W-1:0] hi_idx;
   logic [CH_W-1:0] lo_idx;

   // Descending scan so the lowest matching index in each half is kept.
   always_comb begin
      hi_hit = 1'b0;
      lo_hit = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int c = N_CH - 1; c >= 0; c--) begin
         if (req[c]) begin
            if (c > int'(ptr)) begin
               hi_hit = 1'b1;
               hi_idx = CH_W'(c);
            end else begin
               lo_hit = 1'b1;
               lo_idx = CH_W'(c);
            end
         end
      end
   end

   // Upper half has priority; expand the winner to a one-hot grant.
   always_comb begin
      gnt     = '0;
      gnt_idx = hi_hit ? hi_idx : lo_idx;
      if (hi_hit || lo_hit) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin scheduler sharing one CORDIC phase engine among N_CH channels.
// Optional watchdog on the engine wait: define CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter
   import cordic_arb_pkg::*;
#(
   parameter int N_CH           = 4,
   parameter int BIT_WIDTH_IN   = DEF_BIT_WIDTH_IN,
   parameter int BIT_WIDTH_OUT  = DEF_BIT_WIDTH_OUT,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                  clk_i,
   input  logic                                  reset_ni,
   input  logic [N_CH-1:0]                       req_valid_i,
   output logic [N_CH-1:0]                       req_ready_o,
   input  logic [N_CH-1:0][BIT_WIDTH_IN-1:0]     req_sin_i,
   input  logic [N_CH-1:0][BIT_WIDTH_IN-1:0]     req_cos_i,
   output logic                                  cordic_start_o,
   output logic                                  cordic_reset_o,
   output logic signed [BIT_WIDTH_IN-1:0]        cordic_sin_o,
   output logic signed [BIT_WIDTH_IN-1:0]        cordic_cos_o,
   input  logic signed [BIT_WIDTH_OUT-1:0]       cordic_phi_i,
   input  logic                                  cordic_done_i,
   output logic                                  res_valid_o,
   input  logic                                  res_ready_i,
   output logic signed [BIT_WIDTH_OUT-1:0]       res_phi_o,
   output logic [ch_idx_w(N_CH)-1:0]             res_ch_o,
   output logic                                  timeout_o
);

   localparam int CH_W = ch_idx_w(N_CH);

   if (N_CH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("cordic_arbiter: N_CH must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   cordic_arb_state_e               state_q;
   cordic_arb_state_e               state_d;
   logic [CH_W-1:0]                 last_grant_q;
   logic [N_CH-1:0]                 gnt;
   logic [CH_W-1:0]                 gnt_idx;
   logic                            accept;
   logic                            done_take;
   logic signed [BIT_WIDTH_IN-1:0]  op_sin_p0;
   logic signed [BIT_WIDTH_IN-1:0]  op_cos_p0;
   logic [CH_W-1:0]                 res_ch_p0;
   logic signed [BIT_WIDTH_OUT-1:0] res_phi_p1;

   rr_arbiter #(.N_CH(N_CH)) u_rr (
      .req     (req_valid_i),
      .ptr     (last_grant_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

`ifdef CORDIC_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] wait_cnt_q;
   logic            timeout_hit;

   // Cycles spent in WAIT; cleared whenever the FSM is elsewhere.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wait_cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
         wait_cnt_q <= wait_cnt_q + TO_W'(1);
      end else begin
         wait_cnt_q <= '0;
      end
   end

   // A done in the limit cycle takes precedence over the abort.
   always_comb begin
      timeout_hit = (state_q == ST_WAIT) && !cordic_done_i &&
                    (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
   end

   assign timeout_o      = timeout_hit;
   assign cordic_reset_o = !reset_ni || timeout_hit;
`else
   assign timeout_o      = 1'b0;
   assign cordic_reset_o = !reset_ni;
`endif

   // Next-state logic: grant in IDLE, one start cycle, wait for done, hold result.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      done_take = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|gnt) begin
               accept  = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (cordic_done_i) begin
               done_take = 1'b1;
               state_d   = ST_OUTPUT;
            end
`ifdef CORDIC_ARB_TIMEOUT_EN
            else if (timeout_hit) begin
               state_d = ST_IDLE;
            end
`endif
         end
         ST_OUTPUT: begin
            if (res_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and round-robin pointer; pointer starts at the last channel so ch0 wins first.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= ST_IDLE;
         last_grant_q <= CH_W'(N_CH - 1);
      end else begin
         state_q <= state_d;
         if (accept) begin
            last_grant_q <= gnt_idx;
         end
      end
   end

   // Operand stage (p0) latched on grant; result stage (p1) latched on done.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         op_sin_p0  <= '0;
         op_cos_p0  <= '0;
         res_ch_p0  <= '0;
         res_phi_p1 <= '0;
      end else begin
         if (accept) begin
            op_sin_p0 <= $signed(req_sin_i[gnt_idx]);
            op_cos_p0 <= $signed(req_cos_i[gnt_idx]);
            res_ch_p0 <= gnt_idx;
         end
         if (done_take) begin
            res_phi_p1 <= cordic_phi_i;
         end
      end
   end

   assign req_ready_o    = (state_q == ST_IDLE && reset_ni) ? gnt : '0;
   assign cordic_start_o = (state_q == ST_ISSUE);
   assign cordic_sin_o   = op_sin_p0;
   assign cordic_cos_o   = op_cos_p0;
   assign res_valid_o    = (state_q == ST_OUTPUT);
   assign res_phi_o      = res_phi_p1;
   assign res_ch_o       = res_ch_p0;

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Round-robin scheduler that shares one `CordicFSM` phase engine (24-bit sin/cos in, 26-bit phase out) among `N_CH` requester channels, e.g. the per-baseline demodulator outputs of the NICE phase-tracking chain. It:
- accepts one sin/cos pair at a time through per-channel valid/ready handshakes;
- sequences the engine's `start_i`/`done_o` protocol;
- returns the phase tagged with its channel index through a single valid/ready result port.

## Interface
Parameters:
- `N_CH`, 4, number of requester channels (≥2)
- `BIT_WIDTH_IN`, 24, sin/cos width (signed)
- `BIT_WIDTH_OUT`, 26, phase width (signed)
- `TIMEOUT_CYCLES`, 64, watchdog limit; used only with `CORDIC_ARB_TIMEOUT_EN`

Ports:
- `clk_i`  in  1  clock; one clock domain. Reset is asynchronous and active-low.
- `reset_ni`  in  1  asynchronous active-low reset
- `req_valid_i`  in  N_CH  per-channel request valid
- `req_ready_o`  out  N_CH  per-channel request ready, one-hot or zero
- `req_sin_i`  in  N_CH×BIT_WIDTH_IN  per-channel sine
- `req_cos_i`  in  N_CH×BIT_WIDTH_IN  per-channel cosine
- `cordic_start_o`  out  1  engine start pulse
- `cordic_reset_o`  out  1  engine reset, active-high
- `cordic_sin_o`, `cordic_cos_o`  out  BIT_WIDTH_IN  engine operands
- `cordic_phi_i`  in  BIT_WIDTH_OUT  engine result
- `cordic_done_i`  in  1  engine result valid
- `res_valid_o`  out  1  result valid
- `res_ready_i`  in  1  downstream ready
- `res_phi_o`  out  BIT_WIDTH_OUT  phase result
- `res_ch_o`  out  $clog2(N_CH)  channel index of the result
- `timeout_o`  out  1  watchdog abort pulse

## Operation
FSM states: IDLE, ISSUE, WAIT, OUTPUT.
- **IDLE**
  - Combinational round-robin pick among asserted `req_valid_i`, searching from `last_grant+1` upward with wrap to 0.
  - `req_ready_o[g]=1` for the winner only.
  - On the handshake: latch sin/cos into operand registers, latch `g` into `res_ch`, set `last_grant←g`, go to ISSUE.
  - No valid request: stay in IDLE.
- **ISSUE**
  - `cordic_start_o=1` for exactly one cycle, then go to WAIT.
- **WAIT**
  - Operands stay stable on `cordic_sin_o`/`cordic_cos_o`.
  - First cycle with `cordic_done_i=1`: latch `cordic_phi_i` into `res_phi_o`, go to OUTPUT.
- **OUTPUT**
  - `res_valid_o=1`; `res_phi_o` and `res_ch_o` held stable.
  - On `res_ready_i=1`: go to IDLE.
  - While here, `res_valid_o` is never withdrawn and `req_ready_o` stays all-zero.
- **Arithmetic:** pass-through only; no width conversion. `res_phi_o` is a bit-exact copy of `cordic_phi_i`.
- **Fairness:** a channel that is continuously valid is served at least once every `N_CH` grants.
- **Reset values:**
  - state=IDLE, `last_grant=N_CH-1` (so channel 0 wins first)
  - all outputs 0, except `cordic_reset_o=1` while `reset_ni=0`
- **Reset mid-operation:** any in-flight result is discarded. The engine is reset through `cordic_reset_o`.

## Timing
- Request acceptance to `cordic_start_o`: 1 cycle.
- `cordic_done_i` to `res_valid_o`: 1 cycle (registered).
- Total latency from request acceptance to `res_valid_o` = 2 + engine latency, where engine latency is counted from the start pulse to done.
- No request is accepted on the cycle `res_valid_o` drops; the next grant occurs no earlier than the following cycle in IDLE.
- `cordic_done_i` asserted during ISSUE or the same cycle as start: ignored as stale. Done is sampled only in WAIT.
- Request deasserted before its grant: no effect; the arbiter re-picks each IDLE cycle.

## Configuration
Macro: `CORDIC_ARB_TIMEOUT_EN`.

Defined:
- A counter runs in WAIT (cleared on entry).
- When it reaches `TIMEOUT_CYCLES` without done, in that cycle:
  - `cordic_reset_o=1` and `timeout_o=1`, each for one cycle;
  - the result is dropped;
  - state returns to IDLE;
  - `last_grant` keeps its advanced value.
- Done arriving in the same cycle as the limit wins: normal completion, no timeout.

Undefined:
- No counter; WAIT is unbounded.
- `timeout_o` is tied to 0.
- `cordic_reset_o` is driven only by reset.

## Structure
- Package `cordic_arb_pkg`:
  - state enum `cordic_arb_state_e`
  - default width constants (24/26)
  - channel-index width function
- Sub-module `rr_arbiter`: parameterised by `N_CH`. Inputs are the request vector and the pointer; outputs are the one-hot grant and its encoded index. Combinational; the pointer register lives in the parent.

## Test plan
- Only ch2 valid, sin=0, cos=4194304; model engine with 10-cycle latency returning 0 → start 1 cycle after acceptance, `res_valid_o` 12 cycles after acceptance, `res_phi_o`=0, `res_ch_o`=2.
- All four channels valid continuously → grant order 0,1,2,3,0,…; each result carries the matching `res_ch_o`.
- `res_ready_i` held low 20 cycles in OUTPUT → `res_valid_o`, `res_phi_o` and `res_ch_o` stable; no `req_ready_o` asserted.
- Engine asserts done in the ISSUE cycle, then again 5 cycles later with phi=6588396 → the first done is ignored; the result is 6588396.
- `reset_ni` pulled low during WAIT → all outputs 0 next edge, `cordic_reset_o`=1; after release the first grant goes to ch0.
- With `CORDIC_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=64, engine never finishes → `timeout_o` and `cordic_reset_o` pulse at cycle 64 of WAIT; no `res_valid_o`; the next grant goes to the next channel.
